// File: rtl/fc_frame_feeder.sv
// Host-side frame feeder for the 4x4 FC engine: buffers one frame ahead, drives the row buses
// in step with the engine's 13-phase schedule and streams the captured result rows back out.
module fc_frame_feeder #(
   parameter int PHASES     = 13,
   parameter int LOAD_START = 1,
   parameter int CAP_START  = 9,
   parameter int DATA_W     = 32,
   parameter int RES_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [DATA_W-1:0]  s_w,
   input  logic [DATA_W-1:0]  s_x,
   input  logic [DATA_W-1:0]  s_bias,
   output logic [DATA_W-1:0]  acc_w,
   output logic [DATA_W-1:0]  acc_x,
   output logic [DATA_W-1:0]  acc_bias,
   input  logic [RES_W-1:0]   acc_o1,
   input  logic [RES_W-1:0]   acc_o2,
   input  logic [RES_W-1:0]   acc_o3,
   input  logic [RES_W-1:0]   acc_o4,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [1:0]         m_row,
   output logic [4*RES_W-1:0] m_data,
   output logic               m_last,
   output logic               overflow
);
   localparam int ROWS = 4;
   localparam int PH_W = $clog2(PHASES);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);
   localparam logic [PH_W-1:0] PH_LOAD = PH_W'(LOAD_START);
   localparam logic [PH_W-1:0] PH_CAP  = PH_W'(CAP_START);

   typedef struct packed {
      logic [DATA_W-1:0] w;
      logic [DATA_W-1:0] x;
   } row_t;

   typedef struct packed {
      row_t [ROWS-1:0]   rows;
      logic [DATA_W-1:0] bias;
   } frame_t;

   logic [PH_W-1:0]               phase_q, phase_d;
   frame_t                        fill_q, fill_d, act_q, act_d;
   logic [1:0]                    fill_idx_q, fill_idx_d;
   logic                          pend_q, pend_d, tag_q, tag_d;
   logic [DATA_W-1:0]             acc_w_q, acc_w_d, acc_x_q, acc_x_d, acc_bias_q, acc_bias_d;
   logic [ROWS-1:0][4*RES_W-1:0]  res_q, res_d;
   logic [2:0]                    wr_cnt_q, wr_cnt_d;
   logic [1:0]                    rd_idx_q, rd_idx_d;
   logic                          busy_q, busy_d, cap_ok_q, cap_ok_d, ovf_q, ovf_d;

   logic       beat_ok, in_load, in_cap, cap_first, cap_en, res_pop;
   logic [1:0] load_idx, cap_idx;

   // Fill side and launch into the active frame at the wrap to phase 0.
   always_comb begin
      phase_d    = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
      beat_ok    = s_valid && !pend_q;
      fill_d     = fill_q;
      fill_idx_d = fill_idx_q;
      pend_d     = pend_q;
      act_d      = act_q;
      tag_d      = tag_q;
      if (beat_ok) begin
         fill_d.rows[fill_idx_q] = '{w: s_w, x: s_x};
         if (fill_idx_q == 2'd0) fill_d.bias = s_bias;
         if (fill_idx_q == 2'd3) pend_d = 1'b1;
         fill_idx_d = fill_idx_q + 2'd1;
      end
      if (phase_q == PH_LAST) begin
         tag_d = pend_q;
         if (pend_q) begin
            act_d  = fill_q;
            pend_d = 1'b0;
         end
      end
   end

   // Bus registers are loaded from next-cycle phase/frame so they line up with the phase they serve.
   always_comb begin
      in_load    = (int'(phase_d) >= LOAD_START) && (int'(phase_d) < LOAD_START + ROWS);
      load_idx   = 2'(phase_d - PH_LOAD);
      acc_w_d    = '0;
      acc_x_d    = '0;
      acc_bias_d = '0;
      if (tag_d && in_load) begin
         acc_w_d = act_d.rows[load_idx].w;
         acc_x_d = act_d.rows[load_idx].x;
         if (phase_d == PH_LOAD) acc_bias_d = act_d.bias;
      end
   end

   always_comb begin
      m_valid = busy_q && ({1'b0, rd_idx_q} < wr_cnt_q);
      res_pop = m_valid && m_ready;
   end

   // Result capture; a frame is admitted whole at its first capture phase or dropped whole.
   always_comb begin
      in_cap    = tag_q && (int'(phase_q) >= CAP_START) && (int'(phase_q) < CAP_START + ROWS);
      cap_first = in_cap && (phase_q == PH_CAP);
      cap_idx   = 2'(phase_q - PH_CAP);
      cap_en    = in_cap && (cap_first ? !busy_q : cap_ok_q);
      res_d     = res_q;
      wr_cnt_d  = wr_cnt_q;
      rd_idx_d  = rd_idx_q;
      busy_d    = busy_q;
      cap_ok_d  = cap_ok_q;
      ovf_d     = ovf_q;
      if (cap_first) begin
         cap_ok_d = !busy_q;
         if (busy_q) ovf_d = 1'b1;
      end
      if (cap_en) begin
         res_d[cap_idx] = {acc_o1, acc_o2, acc_o3, acc_o4};
         wr_cnt_d       = wr_cnt_q + 3'd1;
         busy_d         = 1'b1;
      end
      if (res_pop) begin
         if (rd_idx_q == 2'd3) begin
            busy_d   = 1'b0;
            wr_cnt_d = '0;
            rd_idx_d = '0;
         end else begin
            rd_idx_d = rd_idx_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q    <= '0;
         fill_q     <= '0;
         act_q      <= '0;
         fill_idx_q <= '0;
         pend_q     <= 1'b0;
         tag_q      <= 1'b0;
         acc_w_q    <= '0;
         acc_x_q    <= '0;
         acc_bias_q <= '0;
         res_q      <= '0;
         wr_cnt_q   <= '0;
         rd_idx_q   <= '0;
         busy_q     <= 1'b0;
         cap_ok_q   <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         phase_q    <= phase_d;
         fill_q     <= fill_d;
         act_q      <= act_d;
         fill_idx_q <= fill_idx_d;
         pend_q     <= pend_d;
         tag_q      <= tag_d;
         acc_w_q    <= acc_w_d;
         acc_x_q    <= acc_x_d;
         acc_bias_q <= acc_bias_d;
         res_q      <= res_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_idx_q   <= rd_idx_d;
         busy_q     <= busy_d;
         cap_ok_q   <= cap_ok_d;
         ovf_q      <= ovf_d;
      end
   end

   assign s_ready  = !pend_q;
   assign acc_w    = acc_w_q;
   assign acc_x    = acc_x_q;
   assign acc_bias = acc_bias_q;
   assign m_row    = rd_idx_q;
   assign m_data   = res_q[rd_idx_q];
   assign m_last   = m_valid && (rd_idx_q == 2'd3);
   assign overflow = ovf_q;

endmodule
